// File: rtl/multiply_ntts_if.sv
// Handshake and operand/result bundle for the NTT-domain pointwise multiplier.
// The master side (the requester) drives the operands and start. The slave
// side (the multiplier) returns done and the product array.
interface multiply_ntts_if #(
  parameter int N = 256
);
  logic signed [31:0] f_hat [N];
  logic signed [31:0] g_hat [N];
  logic               start_mul;
  logic               done_mul;
  logic signed [31:0] h_hat [N];

  modport master (
    output f_hat, g_hat, start_mul,
    input  done_mul, h_hat
  );

  modport slave (
    input  f_hat, g_hat, start_mul,
    output done_mul, h_hat
  );
endinterface

// File: rtl/multiply_ntts.sv
// Kyber pointwise multiplier in the NTT domain: h_hat = f_hat o g_hat, formed as
// N/2 degree-1 base-case products modulo X^2 - gamma_i.
// The operands are normalised into [0, Q-1] and copied once. After that, each
// pair takes a PROD cycle, which forms four reduced partial products, and then a
// SUM cycle, which writes two output coefficients.
module multiply_ntts #(
  parameter int N = 256,
  parameter int Q = 3329
) (
  input  logic clk,
  input  logic rst,
  multiply_ntts_if.slave bus
);

  localparam int          NP = N / 2;
  localparam int          IW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [31:0] QU = 32'(Q);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_PROD,
    S_SUM,
    S_DONE
  } state_t;

  // gamma_i = 17^(2*brv7(i)+1) mod Q. This is evaluated only at elaboration to fill the ROM.
  function automatic int gamma_calc(input int idx);
    int rev;
    int e;
    int r;
    rev = 0;
    for (int k = 0; k < 7; k++) rev = (rev << 1) | ((idx >> k) & 1);
    e = 2 * rev + 1;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * 17) % Q;
    return r;
  endfunction

  // Signed remainder carries the sign of the dividend, so fold negatives up by Q.
  function automatic logic [11:0] norm_mod(input logic signed [31:0] x);
    logic signed [31:0] r;
    r = x % Q;
    if (r < 0) r = r + Q;
    return r[11:0];
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic            done_q, done_d;
  logic            start_q, start_d;
  logic [11:0]     p00_q, p00_d, p11_q, p11_d, p01_q, p01_d, p10_q, p10_d;
  logic [11:0]     a_q [N];
  logic [11:0]     a_d [N];
  logic [11:0]     b_q [N];
  logic [11:0]     b_d [N];
  logic [11:0]     h_q [N];
  logic [11:0]     h_d [N];
  logic [11:0]     gamma_rom [NP];

  logic [IW:0]     idx0, idx1;
  logic [31:0]     a0, a1, b0, b1, g_cur;
  logic [31:0]     m00, m01, m10, t11, m11;
  logic [31:0]     s_even, s_odd;

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_gamma
      localparam int GV = gamma_calc(gi);
      assign gamma_rom[gi] = 12'(GV);
    end
    for (gi = 0; gi < N; gi++) begin : g_out
      assign bus.h_hat[gi] = {20'd0, h_q[gi]};
    end
  endgenerate

  assign bus.done_mul = done_q;
  // Registering start makes the launch decision come from a flop, not straight from the port.
  assign start_d      = bus.start_mul;

  // Select the operand pair and gamma for the current pair index.
  always_comb begin
    idx0  = {i_q, 1'b0};
    idx1  = {i_q, 1'b1};
    a0    = {20'd0, a_q[idx0]};
    a1    = {20'd0, a_q[idx1]};
    b0    = {20'd0, b_q[idx0]};
    b1    = {20'd0, b_q[idx1]};
    g_cur = {20'd0, gamma_rom[i_q]};
  end

  // Form the four reduced partial products. They are captured only in S_PROD.
  always_comb begin
    m00   = (a0 * b0) % QU;
    m01   = (a0 * b1) % QU;
    m10   = (a1 * b0) % QU;
    t11   = (a1 * b1) % QU;
    m11   = (t11 * g_cur) % QU;
    p00_d = p00_q;
    p11_d = p11_q;
    p01_d = p01_q;
    p10_d = p10_q;
    if (state_q == S_PROD) begin
      p00_d = m00[11:0];
      p11_d = m11[11:0];
      p01_d = m01[11:0];
      p10_d = m10[11:0];
    end
  end

  // Normalise and latch the operands in S_COPY. Otherwise hold the copies.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      if (state_q == S_COPY) begin
        a_d[k] = norm_mod(bus.f_hat[k]);
        b_d[k] = norm_mod(bus.g_hat[k]);
      end
    end
  end

  // Write the two output coefficients of the current pair in S_SUM.
  always_comb begin
    s_even = ({20'd0, p00_q} + {20'd0, p11_q}) % QU;
    s_odd  = ({20'd0, p01_q} + {20'd0, p10_q}) % QU;
    h_d    = h_q;
    if (state_q == S_SUM) begin
      h_d[idx0] = s_even[11:0];
      h_d[idx1] = s_odd[11:0];
    end
  end

  // Next-state logic, pair index and done flag.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start_q) state_d = S_COPY;
      end
      S_COPY: begin
        i_d     = '0;
        state_d = S_PROD;
      end
      S_PROD: state_d = S_SUM;
      S_SUM: begin
        if (i_q == IW'(NP - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_PROD;
        end
      end
      S_DONE: begin
        if (!bus.start_mul) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state. Reset clears everything at once, including partial results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      p00_q   <= '0;
      p11_q   <= '0;
      p01_q   <= '0;
      p10_q   <= '0;
      for (int k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        h_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      done_q  <= done_d;
      start_q <= start_d;
      p00_q   <= p00_d;
      p11_q   <= p11_d;
      p01_q   <= p01_d;
      p10_q   <= p10_d;
      for (int k = 0; k < N; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        h_q[k] <= h_d[k];
      end
    end
  end

endmodule

// File: tb/tb_multiply_ntts.sv
// Directed bench for multiply_ntts. Each run is described by its operand
// pattern and its hand-derived products. The gamma values for the full-array
// checks come from an independent square-and-multiply model.
module tb_multiply_ntts;
  localparam int N = 256;
  localparam int Q = 3329;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  int   exp_h [N];
  logic signed [31:0] snap [N];

  multiply_ntts_if #(.N(N)) bus ();

  multiply_ntts #(.N(N), .Q(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and report any miscompare.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gam(input int i);
    int     rev;
    longint base;
    longint r;
    int     e;
    rev = 0;
    for (int k = 0; k < 7; k++) rev = (rev << 1) | ((i >> k) & 1);
    e    = 2 * rev + 1;
    base = 17;
    r    = 1;
    while (e > 0) begin
      if (e & 1) r = (r * base) % Q;
      base = (base * base) % Q;
      e    = e >> 1;
    end
    return int'(r);
  endfunction

  task automatic fill(input int f0, input int f1, input int g0, input int g1);
    for (int k = 0; k < N; k += 2) begin
      bus.f_hat[k]     = f0;
      bus.f_hat[k + 1] = f1;
      bus.g_hat[k]     = g0;
      bus.g_hat[k + 1] = g1;
    end
  endtask

  task automatic check_array(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < N; k++) if (bus.h_hat[k] !== exp_h[k]) bad++;
    check_val({tag, "_nbad"}, bad, 0);
  endtask

  task automatic count_nonzero(output int nz);
    nz = 0;
    for (int k = 0; k < N; k++) if (bus.h_hat[k] !== 0) nz++;
  endtask

  // Raise start, measure edges from the edge that samples it to done, and leave start high.
  // With scramble set, the operands change mid-run and start is pulsed low. Neither may matter.
  task automatic run_mul(input string tag, input bit scramble);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.start_mul = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (bus.done_mul === 1'b1) begin
        lat = c;
        break;
      end
      if (scramble && c == 20) fill(12345, -7, 999, 42);
      if (scramble && c == 40) bus.start_mul = 1'b0;
      if (scramble && c == 41) bus.start_mul = 1'b1;
    end
    check_val({tag, "_latency"}, lat, 258);
    $display("run %s: done after %0d edges", tag, lat);
  endtask

  task automatic end_run(input string tag);
    @(negedge clk);
    bus.start_mul = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_done_clear"}, {31'd0, bus.done_mul}, 0);
  endtask

  initial begin
    int nz;
    int diff;
    n_vec  = 0;
    n_miss = 0;

    // Reset held with start high: nothing may move.
    rst           = 1'b0;
    bus.start_mul = 1'b1;
    fill(0, 0, 5, 5);
    bus.f_hat[0] = 1;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_done", {31'd0, bus.done_mul}, 0);
    count_nonzero(nz);
    check_val("rst_h_nonzero", nz, 0);
    @(negedge clk);
    bus.start_mul = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_done", {31'd0, bus.done_mul}, 0);

    // Identity: f = delta at 0, g = 5 everywhere.
    run_mul("identity", 1'b0);
    check_val("id_h0", bus.h_hat[0], 5);
    check_val("id_h1", bus.h_hat[1], 5);
    for (int k = 0; k < N; k++) exp_h[k] = (k < 2) ? 5 : 0;
    check_array("identity");
    // Hold start high in S_DONE and change the operands. h_hat must not move.
    for (int k = 0; k < N; k++) snap[k] = bus.h_hat[k];
    fill(77, 88, 99, 11);
    repeat (10) @(posedge clk);
    #1;
    check_val("hold_done", {31'd0, bus.done_mul}, 1);
    diff = 0;
    for (int k = 0; k < N; k++) if (bus.h_hat[k] !== snap[k]) diff++;
    check_val("hold_h_stable", diff, 0);
    end_run("identity");

    // Gamma extraction. The operands are scrambled and start is pulsed mid-run.
    fill(0, 1, 0, 1);
    run_mul("gamma", 1'b1);
    check_val("gam_h0", bus.h_hat[0], 17);
    check_val("gam_h2", bus.h_hat[2], 3312);
    check_val("gam_h4", bus.h_hat[4], 2761);
    check_val("gam_h6", bus.h_hat[6], 568);
    for (int i = 0; i < N / 2; i++) begin
      exp_h[2 * i]     = gam(i);
      exp_h[2 * i + 1] = 0;
    end
    check_array("gamma");
    end_run("gamma");

    // Max operands, then the same operands written as -1.
    fill(3328, 3328, 3328, 3328);
    run_mul("max", 1'b0);
    check_val("max_h0", bus.h_hat[0], 18);
    check_val("max_h1", bus.h_hat[1], 2);
    check_val("max_h2", bus.h_hat[2], 3313);
    check_val("max_h3", bus.h_hat[3], 2);
    for (int i = 0; i < N / 2; i++) begin
      exp_h[2 * i]     = (1 + gam(i)) % Q;
      exp_h[2 * i + 1] = 2;
    end
    check_array("max");
    end_run("max");

    fill(-1, -1, -1, -1);
    run_mul("neg1", 1'b0);
    check_val("neg_h0", bus.h_hat[0], 18);
    check_val("neg_h1", bus.h_hat[1], 2);
    check_val("neg_h2", bus.h_hat[2], 3313);
    check_val("neg_h3", bus.h_hat[3], 2);
    check_array("neg1");
    end_run("neg1");

    // Extreme inputs: -2^31 -> 988, 2^31-1 -> 2340, Q+1 -> 1.
    fill(32'sh8000_0000, 0, 32'sh7fff_ffff, Q + 1);
    run_mul("extreme", 1'b0);
    check_val("ext_h0", bus.h_hat[0], 1594);
    check_val("ext_h1", bus.h_hat[1], 988);
    check_val("ext_h255", bus.h_hat[255], 988);
    for (int k = 0; k < N; k++) exp_h[k] = (k % 2 == 0) ? 1594 : 988;
    check_array("extreme");
    end_run("extreme");

    // Reset 100 cycles into a run must clear everything immediately.
    fill(2, 3, 4, 5);
    @(negedge clk);
    bus.start_mul = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_done", {31'd0, bus.done_mul}, 0);
    count_nonzero(nz);
    check_val("midrst_h_nonzero", nz, 0);
    @(negedge clk);
    bus.start_mul = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Run after the aborted one: h[2i] = 8 + 15*gamma_i, h[2i+1] = 10 + 12.
    run_mul("after_rst", 1'b0);
    check_val("ar_h0", bus.h_hat[0], 263);
    check_val("ar_h1", bus.h_hat[1], 22);
    for (int i = 0; i < N / 2; i++) begin
      exp_h[2 * i]     = (8 + 15 * gam(i)) % Q;
      exp_h[2 * i + 1] = 22;
    end
    check_array("after_rst");
    end_run("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard stop so the bench always ends, with a failure line first.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multiply_ntts.md
Name: multiply_ntts

Overview:
- Pointwise multiplier for Kyber NTT-domain polynomials. Computes h_hat = f_hat ∘ g_hat as 128 degree-1 base-case products modulo X^2 − gamma_i.
- Sits directly upstream of inverse_ntt; its h_hat output feeds that block's f input unchanged.
- Uses the same start/done, full-array interface style as the NTT blocks.

Parameters:
- N, 256, polynomial length; must be even.
- Q, 3329, modulus.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; the block is in reset while rst=0.
- f_hat  input  32 signed x N  first operand, NTT domain.
- g_hat  input  32 signed x N  second operand, NTT domain.
- start_mul  input  1  level start request.
- done_mul  output  1  result valid; registered.
- h_hat  output  32 signed x N  product, NTT domain, each element in [0, Q-1].

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, done_mul=0, every h_hat[k]=0.
  - Pair index i=0; internal operand copies and product registers cleared.
- Gamma table, 128 constants: gamma_i = 17^(2*brv7(i)+1) mod Q.
  - First entries: 17, 3312, 2761, 568.
  - Stored as a constant ROM indexed by i.
- Input normalisation (applied in S_COPY to every element): r = x % Q; if r<0 then r += Q. Result is in [0, Q-1], 12 bits.
- FSM:
  - S_IDLE: done_mul=0. Go to S_COPY when start_mul=1.
  - S_COPY: latch the normalised f_hat and g_hat into internal arrays a[] and b[]; set i=0. Go to S_PROD.
  - S_PROD: with a0=a[2i], a1=a[2i+1], b0=b[2i], b1=b[2i+1], register four values:
    - p00 = a0*b0 % Q
    - p11 = (a1*b1 % Q) * gamma_i % Q
    - p01 = a0*b1 % Q
    - p10 = a1*b0 % Q
    - Then go to S_SUM.
  - S_SUM: write h_hat[2i] = (p00+p11) % Q and h_hat[2i+1] = (p01+p10) % Q.
    - If i==N/2-1: set done_mul=1 and go to S_DONE.
    - Else: i += 1 and go to S_PROD.
  - S_DONE: done_mul held at 1 while start_mul=1. When start_mul=0, return to S_IDLE and clear done_mul on that edge.
- Arithmetic:
  - All intermediates are non-negative, computed at 32 bits unsigned before reduction.
  - No product exceeds 24 bits before its modulo.
- Latency:
  - start_mul sampled high at edge E gives done_mul=1 after edge E+2+N.
  - With N=256 that is E+258: 1 COPY cycle + 128 x (PROD, SUM).
- Boundary conditions:
  - f_hat and g_hat are sampled only in S_COPY; later changes have no effect on the result.
  - start_mul is ignored in S_COPY, S_PROD and S_SUM; there is no restart mid-operation.
  - h_hat keeps its previous contents until overwritten pair by pair. It is only guaranteed consistent while done_mul=1.
  - h_hat is stable throughout S_DONE.
  - Reset asserted mid-operation aborts immediately to the full reset state; partial results are cleared to 0.
  - Back-to-back use: drop start_mul for at least one cycle after done_mul, then reassert it. The second run produces an independent correct result.
  - Inputs equal to ±Q or outside (−2^31, 2^31) are legal; normalisation defines the result.

Test Plan:
- Reset: hold rst=0 with start_mul=1 → done_mul=0, all h_hat=0, no state advance; release rst → S_IDLE.
- Identity: f_hat[0]=1, rest 0; g_hat all 5 → h_hat[0]=5, h_hat[1]=5, h_hat[2..255]=0; done_mul rises exactly 258 cycles after start is sampled.
- Gamma check: f_hat[2i+1]=g_hat[2i+1]=1 for all i, rest 0 → h_hat[0]=17, h_hat[2]=3312, h_hat[4]=2761, h_hat[6]=568, all odd indices 0.
- Max and negative operands: f_hat=g_hat all 3328, then repeated with all −1 → identical results: h_hat[0]=18, h_hat[1]=2, h_hat[2]=3313, h_hat[3]=2.
- Handshake: hold start_mul high after done → stays in S_DONE with h_hat stable; drop start_mul → done_mul=0 next edge; reassert with new operands → new correct result.
- Reset mid-run: assert rst=0 at cycle 100 of a run → done_mul=0 and h_hat all 0 immediately; a subsequent run completes correctly.
